// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: word size, PC step, canonical NOP and the fetch entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;
    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;   // addi x0,x0,0
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One fetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Instruction fetch is word aligned; the low two address bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Fetch FIFO: DEPTH-entry synchronous queue of {pc, inst}; flush wins over push/pop.
// Latency: a push is visible at head_dat the cycle after it is written; head is read combinationally.
// Backpressure: push is ignored when full, pop is ignored when empty; the owner keeps both from happening.
// Ports: clk, rst (async, active-high), push/push_dat, pop, flush, full, empty, count, head_dat.
module if_fetch_fifo
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [ENTRY_W-1:0]             push_dat,
    input  logic                           pop,
    input  logic                           flush,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [ENTRY_W-1:0]             head_dat
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign head_dat = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches, buffers returns and presents {pc, inst} to IF/ID.
// Latency: memory latency + 1 cycle from accepted request to presentation; head is presented combinationally.
// Backpressure: stall holds the head; requests only issue while FIFO occupancy plus in-flight stays below DEPTH.
// Ports: clk, rst; stall, jb, jb_target from the pipeline; imem_req/addr/ready/rvalid/rdata to instruction
//        memory; out_pc, out_inst, out_valid to IF/ID.
module if_fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP      = NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jb,
    input  logic [31:0] jb_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_valid
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      pc_reg;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   occupancy;
    logic             issue_hs;
    logic             rsp_keep;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    fetch_entry_t     push_dat;
    fetch_entry_t     head_dat;

    // PC tags of accepted requests whose responses will be kept, oldest first.
    logic [31:0]      tag_mem [DEPTH];
    logic [PTR_W-1:0] tag_wr_ptr;
    logic [PTR_W-1:0] tag_rd_ptr;

    // Counting in-flight requests against FIFO space guarantees every response has a slot.
    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
    assign imem_req  = !rst && !jb && (occupancy < (CNT_W+1)'(DEPTH));
    assign imem_addr = pc_reg;
    assign issue_hs  = imem_req && imem_ready;

    // Responses still owed to a pre-redirect path are discarded, as is one landing in the redirect cycle.
    assign rsp_keep  = imem_rvalid && !jb && (drop_cnt == '0);
    assign fifo_push = rsp_keep && !fifo_full;
    assign fifo_pop  = !fifo_empty && !stall && !jb;
    assign push_dat  = '{pc: tag_mem[tag_rd_ptr], inst: imem_rdata};

    assign out_valid = !fifo_empty;
    assign out_pc    = fifo_empty ? 32'h0 : head_dat.pc;
    assign out_inst  = fifo_empty ? NOP   : head_dat.inst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg     <= RESET_PC;
            inflight   <= '0;
            drop_cnt   <= '0;
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
        end else begin
            // No request issues during jb, so only the response side moves inflight then.
            inflight <= inflight + CNT_W'(issue_hs) - CNT_W'(imem_rvalid);
            if (jb) begin
                pc_reg     <= word_align(jb_target);
                drop_cnt   <= inflight - CNT_W'(imem_rvalid);
                tag_wr_ptr <= '0;
                tag_rd_ptr <= '0;
            end else begin
                if (issue_hs) begin
                    pc_reg     <= pc_reg + PC_INC;
                    tag_wr_ptr <= tag_wr_ptr + 1'b1;
                end
                if (imem_rvalid) begin
                    if (drop_cnt != '0) drop_cnt   <= drop_cnt - 1'b1;
                    else                tag_rd_ptr <= tag_rd_ptr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue_hs) tag_mem[tag_wr_ptr] <= pc_reg;
    end

    if_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat (push_dat),
        .pop      (fifo_pop),
        .flush    (jb),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .head_dat (head_dat)
    );

endmodule
